// File: rtl/const_alu_pipe_if.sv
// Streaming bus for const_alu_pipe: input handshake, operand/opcode fields,
// constant-write port, and the registered result with its status flags.
interface const_alu_pipe_if #(
  parameter int WIDTH  = 8,
  parameter int CSEL_W = 2
);
  logic              in_valid;
  logic              in_ready;
  logic [WIDTH-1:0]  in_data;
  logic [CSEL_W-1:0] in_csel;
  logic [1:0]        in_op;
  logic              in_acc;
  logic              acc_clr;
  logic              cfg_we;
  logic [CSEL_W-1:0] cfg_addr;
  logic [WIDTH-1:0]  cfg_data;
  logic              out_valid;
  logic              out_ready;
  logic [WIDTH-1:0]  out_data;
  logic              out_carry;
  logic              out_ovf;
  logic              out_zero;

  modport slave (
    input  in_valid, in_data, in_csel, in_op, in_acc, acc_clr,
           cfg_we, cfg_addr, cfg_data, out_ready,
    output in_ready, out_valid, out_data, out_carry, out_ovf, out_zero
  );

  modport master (
    output in_valid, in_data, in_csel, in_op, in_acc, acc_clr,
           cfg_we, cfg_addr, cfg_data, out_ready,
    input  in_ready, out_valid, out_data, out_carry, out_ovf, out_zero
  );
endinterface

// File: rtl/const_alu_pipe.sv
// Registered constant-select ALU: operand (or accumulator) combined with one of
// NCONST writable constants, one output register behind a valid/ready handshake.
module const_alu_pipe #(
  parameter int WIDTH  = 8,
  parameter int CSEL_W = 2
) (
  input logic            clk,
  input logic            reset,
  const_alu_pipe_if.slave bus
);
  localparam int NCONST = 2 ** CSEL_W;

  typedef enum logic {EMPTY, FULL} outState_t;

  outState_t stateReg, stateNext;

  logic [NCONST-1:0][WIDTH-1:0] constVec;
  logic [WIDTH-1:0] accReg, accNext;
  logic [WIDTH-1:0] dataReg, dataNext;
  logic             carryReg, carryNext;
  logic             ovfReg, ovfNext;

  logic             accept;
  logic [WIDTH-1:0] opA, opB, result;
  logic             carry, ovf;
  logic [WIDTH:0]   sumWide, diffWide;

  // Constant bank; an accept in the same cycle as a write still sees the old value.
  for (genvar gi = 0; gi < NCONST; gi++) begin : gen_const
    logic [WIDTH-1:0] constReg;

    always_ff @(posedge clk) begin
      if (reset) begin
        constReg <= WIDTH'(gi + 1);
      end else if (bus.cfg_we && (bus.cfg_addr == CSEL_W'(gi))) begin
        constReg <= bus.cfg_data;
      end
    end

    assign constVec[gi] = constReg;
  end

  assign bus.in_ready = (stateReg == EMPTY) || bus.out_ready;
  assign accept       = bus.in_valid && bus.in_ready;

  assign opA = bus.in_acc ? accReg : bus.in_data;
  assign opB = constVec[bus.in_csel];

  always_comb begin
    sumWide  = {1'b0, opA} + {1'b0, opB};
    diffWide = {1'b0, opA} - {1'b0, opB};
    result   = opA;
    carry    = 1'b0;
    ovf      = 1'b0;
    case (bus.in_op)
      2'd1: begin
        result = sumWide[WIDTH-1:0];
        carry  = sumWide[WIDTH];
        ovf    = (opA[WIDTH-1] == opB[WIDTH-1]) && (result[WIDTH-1] != opA[WIDTH-1]);
      end
      2'd2: begin
        // The extra top bit of the widened difference is the unsigned borrow.
        result = diffWide[WIDTH-1:0];
        carry  = diffWide[WIDTH];
        ovf    = (opA[WIDTH-1] != opB[WIDTH-1]) && (result[WIDTH-1] != opA[WIDTH-1]);
      end
      2'd3: result = opA & opB;
      default: result = opA;
    endcase
  end

  always_comb begin
    stateNext = stateReg;
    dataNext  = dataReg;
    carryNext = carryReg;
    ovfNext   = ovfReg;
    accNext   = accReg;

    if (accept) begin
      stateNext = FULL;
      dataNext  = result;
      carryNext = carry;
      ovfNext   = ovf;
    end else if (bus.out_ready) begin
      stateNext = EMPTY;
    end

    // Clear wins over an accumulate write-back in the same cycle.
    if (bus.acc_clr) begin
      accNext = '0;
    end else if (accept && bus.in_acc) begin
      accNext = result;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      stateReg <= EMPTY;
      dataReg  <= '0;
      carryReg <= 1'b0;
      ovfReg   <= 1'b0;
      accReg   <= '0;
    end else begin
      stateReg <= stateNext;
      dataReg  <= dataNext;
      carryReg <= carryNext;
      ovfReg   <= ovfNext;
      accReg   <= accNext;
    end
  end

  assign bus.out_valid = (stateReg == FULL);
  assign bus.out_data  = dataReg;
  assign bus.out_carry = carryReg;
  assign bus.out_ovf   = ovfReg;
  assign bus.out_zero  = (dataReg == '0);
endmodule

// File: tb/tb_const_alu_pipe.sv
// Bench for const_alu_pipe: directed scenarios with literal expectations, then
// random traffic checked every cycle against a transaction-level model.
module tb_const_alu_pipe;
  localparam int WIDTH  = 8;
  localparam int CSEL_W = 2;
  localparam int NCONST = 4;
  localparam int MOD    = 256;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  const_alu_pipe_if #(.WIDTH(WIDTH), .CSEL_W(CSEL_W)) bus ();

  const_alu_pipe #(.WIDTH(WIDTH), .CSEL_W(CSEL_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int checks   = 0;
  int failures = 0;

  // Model state: constant table, accumulator and the single output slot.
  int mConst[NCONST];
  int mAcc   = 0;
  int mValid = 0;
  int mData  = 0;
  int mCarry = 0;
  int mOvf   = 0;
  bit mLive  = 1'b0;

  task automatic chk(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d time=%0t", name, act, exp, $time);
    end
  endtask

  function automatic int toSigned(int v);
    return (v >= MOD / 2) ? v - MOD : v;
  endfunction

  function automatic int sOvf(int s);
    return ((s > MOD / 2 - 1) || (s < -(MOD / 2))) ? 1 : 0;
  endfunction

  always @(posedge clk) begin : model
    int a, b, r, c, o, s;
    if (reset) begin
      for (int i = 0; i < NCONST; i++) mConst[i] <= (i + 1) % MOD;
      mAcc   <= 0;
      mValid <= 0;
      mData  <= 0;
      mCarry <= 0;
      mOvf   <= 0;
      mLive  <= 1'b1;
    end else if (mLive) begin
      if (bus.in_valid && (mValid == 0 || bus.out_ready)) begin
        a = bus.in_acc ? mAcc : int'(bus.in_data);
        b = mConst[int'(bus.in_csel)];
        c = 0;
        o = 0;
        case (int'(bus.in_op))
          1: begin
            s = a + b;
            r = s % MOD;
            c = (s >= MOD) ? 1 : 0;
            o = sOvf(toSigned(a) + toSigned(b));
          end
          2: begin
            r = (a - b + MOD) % MOD;
            c = (a < b) ? 1 : 0;
            o = sOvf(toSigned(a) - toSigned(b));
          end
          3: r = a & b;
          default: r = a;
        endcase
        mValid <= 1;
        mData  <= r;
        mCarry <= c;
        mOvf   <= o;
        if (bus.in_acc && !bus.acc_clr) mAcc <= r;
        $display("txn op=%0d a=%0d b=%0d result=%0d carry=%0d ovf=%0d", int'(bus.in_op), a, b, r, c, o);
      end else if (bus.out_ready) begin
        mValid <= 0;
      end
      if (bus.acc_clr) mAcc <= 0;
      if (bus.cfg_we) mConst[int'(bus.cfg_addr)] <= int'(bus.cfg_data);
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (mLive) begin
      chk("in_ready", int'(bus.in_ready), (mValid == 0 || bus.out_ready) ? 1 : 0);
      chk("out_valid", int'(bus.out_valid), mValid);
      if (mValid != 0) begin
        chk("out_data", int'(bus.out_data), mData);
        chk("out_carry", int'(bus.out_carry), mCarry);
        chk("out_ovf", int'(bus.out_ovf), mOvf);
        chk("out_zero", int'(bus.out_zero), (mData == 0) ? 1 : 0);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic setIn(bit v, int d, int cs, int op, bit acc, bit clr);
    bus.in_valid = v;
    bus.in_data  = WIDTH'(d);
    bus.in_csel  = CSEL_W'(cs);
    bus.in_op    = 2'(op);
    bus.in_acc   = acc;
    bus.acc_clr  = clr;
  endtask

  task automatic checkLit(string name, int d, int c, int o);
    chk({name, "_valid"}, int'(bus.out_valid), 1);
    chk({name, "_data"}, int'(bus.out_data), d);
    chk({name, "_carry"}, int'(bus.out_carry), c);
    chk({name, "_ovf"}, int'(bus.out_ovf), o);
    chk({name, "_zero"}, int'(bus.out_zero), (d == 0) ? 1 : 0);
  endtask

  initial begin
    reset         = 1'b1;
    bus.out_ready = 1'b0;
    bus.cfg_we    = 1'b0;
    bus.cfg_addr  = '0;
    bus.cfg_data  = '0;
    setIn(0, 0, 0, 0, 0, 0);
    step();
    step();
    chk("rst_valid", int'(bus.out_valid), 0);
    chk("rst_data", int'(bus.out_data), 0);
    chk("rst_carry", int'(bus.out_carry), 0);
    chk("rst_ovf", int'(bus.out_ovf), 0);
    chk("rst_zero", int'(bus.out_zero), 1);
    reset = 1'b0;

    // Basic ADD with the reset-value constant 3.
    bus.out_ready = 1'b1;
    setIn(1, 7, 2, 1, 0, 0); step(); checkLit("t1_add", 10, 0, 0);

    // SUB, SUB with borrow, ADD with signed overflow, back to back.
    setIn(1, 3, 1, 2, 0, 0);   step(); checkLit("t2_sub", 1, 0, 0);
    setIn(1, 1, 2, 2, 0, 0);   step(); checkLit("t2_borrow", 254, 1, 0);
    setIn(1, 127, 0, 1, 0, 0); step(); checkLit("t2_ovf", 128, 0, 1);
    setIn(0, 0, 0, 0, 0, 0);   step(); chk("t2_drain", int'(bus.out_valid), 0);

    // Backpressure: first result held, second input waits for out_ready.
    bus.out_ready = 1'b0;
    setIn(1, 5, 0, 0, 0, 0); step(); checkLit("t3_first", 5, 0, 0);
    setIn(1, 6, 0, 0, 0, 0);
    chk("t3_stall_ready", int'(bus.in_ready), 0);
    step(); checkLit("t3_held", 5, 0, 0);
    bus.out_ready = 1'b1;
    step(); checkLit("t3_second", 6, 0, 0);
    setIn(0, 0, 0, 0, 0, 0); step(); chk("t3_drain", int'(bus.out_valid), 0);

    // Accumulate with constant 4, then clear colliding with an accept.
    setIn(0, 0, 0, 0, 0, 1); step();
    for (int k = 1; k <= 4; k++) begin
      setIn(1, int'($urandom_range(255)), 3, 1, 1, 0);
      step();
      checkLit("t4_acc", 4 * k, 0, 0);
    end
    setIn(1, int'($urandom_range(255)), 3, 1, 1, 1); step(); checkLit("t4_clr_same", 20, 0, 0);
    setIn(1, int'($urandom_range(255)), 3, 1, 1, 0); step(); checkLit("t4_after_clr", 4, 0, 0);

    // Constant write in the same cycle as a read of that constant.
    bus.cfg_we = 1'b1; bus.cfg_addr = 2'd0; bus.cfg_data = 8'h55;
    setIn(1, 0, 0, 1, 0, 0); step();
    bus.cfg_we = 1'b0;
    checkLit("t5_old_const", 1, 0, 0);
    step(); checkLit("t5_new_const", 85, 0, 0);

    // Reset with a held result; constant 0 must return to 1.
    bus.out_ready = 1'b0;
    setIn(1, 9, 0, 0, 0, 0); step(); chk("t6_full", int'(bus.out_valid), 1);
    reset = 1'b1;
    setIn(0, 0, 0, 0, 0, 0); step();
    chk("t6_rst_valid", int'(bus.out_valid), 0);
    chk("t6_rst_zero", int'(bus.out_zero), 1);
    reset = 1'b0;
    bus.out_ready = 1'b1;
    setIn(1, 255, 0, 3, 0, 0); step(); checkLit("t6_and", 1, 0, 0);

    // Random traffic; the per-cycle compare does the checking.
    for (int n = 0; n < 600; n++) begin
      reset         = ($urandom_range(199) == 0);
      bus.out_ready = ($urandom_range(3) != 0);
      bus.cfg_we    = ($urandom_range(5) == 0);
      bus.cfg_addr  = CSEL_W'($urandom_range(NCONST - 1));
      bus.cfg_data  = WIDTH'($urandom_range(MOD - 1));
      setIn($urandom_range(3) != 0, int'($urandom_range(MOD - 1)),
            int'($urandom_range(NCONST - 1)), int'($urandom_range(3)),
            $urandom_range(2) == 0, $urandom_range(9) == 0);
      step();
    end
    reset = 1'b0;
    bus.cfg_we = 1'b0;
    setIn(0, 0, 0, 0, 0, 0);
    step();
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
